dpram_fifo_ctrl: RTL
====================

DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 SHALL have parameter addr_width, default 8, RAM address width; FIFO depth is 2^addr_width words.
REQ-002 SHALL have parameter data_width, default 8, word width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clock  input  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous flush; empties the FIFO and clears sticky flags.
REQ-007 SHALL have port wr_en  input  1  push request.
REQ-008 SHALL have port wr_data  input  data_width  push data.
REQ-009 SHALL have port rd_en  input  1  pop request.
REQ-010 SHALL have port rd_data  output  data_width  popped word, valid only while rd_valid=1.
REQ-011 SHALL have port rd_valid  output  1  high exactly one cycle after each accepted pop.
REQ-012 SHALL have ports full, empty  output  1 each  occupancy flags.
REQ-013 SHALL have port count  output  addr_width+1  current occupancy, 0..2^addr_width.
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags.
REQ-015 SHALL have RAM port A outputs ram_address_a (addr_width), ram_data_a (data_width), ram_wren_a, ram_enable_a, ram_cs_a (1 each); this is the write side.
REQ-016 SHALL have RAM port B outputs ram_address_b (addr_width), ram_enable_b, ram_cs_b (1 each) and input ram_q_b (data_width); this is the read side. RAM port B read data is registered: one cycle of latency.

Function
REQ-017 Push SHALL be accepted iff wr_en=1 and full=0; pop SHALL be accepted iff rd_en=1 and empty=0; full and empty are evaluated from the registered count.
REQ-018 On an accepted push:
  - ram_address_a SHALL equal wr_ptr;
  - ram_data_a SHALL equal wr_data;
  - ram_wren_a SHALL be 1;
  - wr_ptr SHALL increment modulo 2^addr_width.
REQ-019 On an accepted pop:
  - ram_address_b SHALL equal rd_ptr;
  - rd_ptr SHALL increment modulo 2^addr_width;
  - rd_valid SHALL be 1 in the next cycle.
REQ-020 ram_address_a, ram_data_a and ram_address_b SHALL be driven combinationally from the pointers and wr_data in the request cycle.
REQ-021 ram_wren_a SHALL be 0 in every cycle without an accepted push.
REQ-022 ram_enable_a, ram_cs_a, ram_enable_b and ram_cs_b SHALL be constant 1.
REQ-023 rd_data SHALL pass ram_q_b through combinationally.
REQ-024 count SHALL update as follows:
  - +1 on a push-only cycle;
  - -1 on a pop-only cycle;
  - unchanged when both a push and a pop are accepted, or when neither is.
REQ-025 full SHALL equal (count == 2^addr_width); empty SHALL equal (count == 0).
REQ-026 When full and both wr_en and rd_en are high, the pop SHALL be accepted, the push SHALL be rejected, and overflow SHALL set.
REQ-027 When empty and both wr_en and rd_en are high, the push SHALL be accepted, the pop SHALL be rejected, and underflow SHALL set.
REQ-028 overflow SHALL set on any cycle with wr_en=1 and full=1; underflow SHALL set on any cycle with rd_en=1 and empty=1; both SHALL hold until reset or clear.
REQ-029 A write and a read SHALL never target the same RAM address in the same cycle; this follows from REQ-017 and needs no extra logic.
REQ-030 When clear=1:
  - wr_ptr, rd_ptr and count SHALL go to 0;
  - overflow and underflow SHALL go to 0;
  - rd_valid SHALL be 0 next cycle;
  - push and pop requests in that cycle SHALL be ignored, with ram_wren_a=0.
REQ-031 Pointer wrap SHALL be transparent: data order is preserved across the 2^addr_width boundary.

Reset
REQ-032 When reset=1 in a cycle, then from the next edge:
  - wr_ptr, rd_ptr and count SHALL be 0;
  - empty SHALL be 1 and full SHALL be 0;
  - rd_valid, overflow and underflow SHALL be 0.
REQ-033 While reset=1, ram_wren_a SHALL be 0 and all requests SHALL be ignored.
REQ-034 Reset SHALL take priority over clear.
REQ-035 A pop accepted in the cycle before reset asserts SHALL NOT produce rd_valid after reset.
REQ-036 RAM contents SHALL NOT be cleared by reset or clear.

Verification
REQ-037 Basic order (addr_width=2): push 0x11,0x22,0x33 on consecutive cycles, then 3 pops -> rd_valid on 3 consecutive cycles with rd_data 0x11,0x22,0x33; count goes 0,1,2,3,2,1,0.
REQ-038 Full boundary (addr_width=2): push 4 words -> full=1, count=4; 5th push -> word dropped, overflow=1, ram_wren_a=0.
REQ-039 Simultaneous at full: full, wr_en=rd_en=1 -> oldest word popped, count 4->3, push dropped, overflow=1.
REQ-040 Simultaneous at empty: empty, wr_en=rd_en=1 -> count 0->1, rd_valid=0 next cycle, underflow=1; next pop returns the pushed word.
REQ-041 Wrap (addr_width=2): push 3 / pop 3 twice with data 0xA0..0xA5 -> pops return 0xA0..0xA5 in order; pointers wrap 3->0.
REQ-042 Reset mid-operation: count=2 with a pop accepted, reset asserted next cycle -> rd_valid=0 after reset, count=0, empty=1, flags=0; clear behaves the same.

Source files
------------

// File: rtl/dpram_fifo_ctrl_if.sv
// User-side FIFO bus for dpram_fifo_ctrl: push/pop requests, read data and status.
interface dpram_fifo_ctrl_if #(
  parameter int addr_width = 8,
  parameter int data_width = 8
);
  logic                  clear;
  logic                  wr_en;
  logic [data_width-1:0] wr_data;
  logic                  rd_en;
  logic [data_width-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic [addr_width:0]   count;
  logic                  overflow;
  logic                  underflow;

  // FIFO user: issues requests, observes data and status
  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, count, overflow, underflow
  );

  // FIFO controller
  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM: port A writes, port B reads
// with one cycle of registered read latency. Tracks pointers, occupancy and
// sticky overflow/underflow flags.
module dpram_fifo_ctrl #(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  dpram_fifo_ctrl_if.slave      fifo,
  output logic [addr_width-1:0] ram_address_a,
  output logic [data_width-1:0] ram_data_a,
  output logic                  ram_wren_a,
  output logic                  ram_enable_a,
  output logic                  ram_cs_a,
  output logic [addr_width-1:0] ram_address_b,
  output logic                  ram_enable_b,
  output logic                  ram_cs_b,
  input  logic [data_width-1:0] ram_q_b
);

  localparam logic [addr_width:0]   DEPTH  = {1'b1, {addr_width{1'b0}}};
  localparam logic [addr_width:0]   CNT_1  = {{addr_width{1'b0}}, 1'b1};
  localparam logic [addr_width-1:0] PTR_1  = {{(addr_width-1){1'b0}}, 1'b1};

  logic [addr_width-1:0] wr_ptr, rd_ptr;
  logic [addr_width:0]   count_q;
  logic                  rd_vld_q, ovf_q, udf_q;
  logic                  full, empty, push_ok, pop_ok;

  // Flags come from the registered count, so acceptance never depends on
  // same-cycle requests; a read and write therefore never share an address.
  assign full    = (count_q == DEPTH);
  assign empty   = (count_q == '0);
  assign push_ok = !reset && !fifo.clear && fifo.wr_en && !full;
  assign pop_ok  = !reset && !fifo.clear && fifo.rd_en && !empty;

  // RAM side: addresses and write data are pure functions of this cycle
  assign ram_address_a = wr_ptr;
  assign ram_data_a    = fifo.wr_data;
  assign ram_wren_a    = push_ok;
  assign ram_enable_a  = 1'b1;
  assign ram_cs_a      = 1'b1;
  assign ram_address_b = rd_ptr;
  assign ram_enable_b  = 1'b1;
  assign ram_cs_b      = 1'b1;

  // User side: RAM read data lines up with rd_valid one cycle after the pop
  assign fifo.rd_data   = ram_q_b;
  assign fifo.rd_valid  = rd_vld_q;
  assign fifo.full      = full;
  assign fifo.empty     = empty;
  assign fifo.count     = count_q;
  assign fifo.overflow  = ovf_q;
  assign fifo.underflow = udf_q;

  // Pointer, occupancy, read-valid and sticky flag state; reset beats clear,
  // and both drop any in-flight read-valid. RAM contents are left untouched.
  always_ff @(posedge clock) begin
    if (reset || fifo.clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      rd_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_1;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_1;
        2'b01:   count_q <= count_q - CNT_1;
        default: count_q <= count_q;
      endcase
      rd_vld_q <= pop_ok;
      if (fifo.wr_en && full)  ovf_q <= 1'b1;
      if (fifo.rd_en && empty) udf_q <= 1'b1;
    end
  end

endmodule
